oam_dma: RTL and testbench

OAM DMA controller for the NES-style system. A CPU write to the $4014 register starts a transfer of one 256-byte page ($XX00–$XXFF) from the CPU address space into PPU sprite memory through the $2004 data port. During the transfer the block drives the system bus address and holds the CPU off the bus. It supplies the `dma_en`/DMA address that the top-level bus mux consumes, and reads back the registered bus read data (RAM or cartridge).

---
 rtl/nes_pkg.sv | 25 ++
 rtl/oam_dma.sv | 106 ++++++++++
 tb/tb_oam_dma.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_pkg.sv
// Shared NES system definitions: DMA state encoding, register addresses
// and CPU bus decode widths.
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

  localparam int CPU_ADDR_W = 16;
  localparam int CPU_DATA_W = 8;

  localparam logic [CPU_ADDR_W-1:0] ADDR_OAMDMA  = 16'h4014;
  localparam logic [CPU_ADDR_W-1:0] ADDR_OAMDATA = 16'h2004;

  // Full 16-bit decode of a CPU write to the OAM DMA trigger register.
  function automatic logic is_oamdma_write(input logic [CPU_ADDR_W-1:0] addr,
                                           input logic wr);
    return wr && (addr == ADDR_OAMDMA);
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA controller: copies one 256-byte CPU page into PPU sprite memory
// through the OAM data port while holding the CPU off the bus.
module oam_dma
  import nes_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        cpu_clock,
  input  logic        reset_n,
  input  logic        reg_wr_en,
  input  logic [7:0]  reg_din,
  input  logic [7:0]  bus_din,
  output logic        dma_en,
  output logic [15:0] dma_addr,
  output logic        oam_wr_en,
  output logic [7:0]  oam_din,
  output logic        done
);

  // Last value of the wait counter before the read data is valid.
  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

  dma_state_t  state;
  logic [7:0]  page;
  logic [7:0]  index;
  logic [1:0]  wait_cnt;
  logic        parity;
  logic [7:0]  oam_data;

  // Free-running cycle parity used to decide whether an alignment cycle is needed.
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) parity <= 1'b0;
    else          parity <= ~parity;
  end

  // Transfer FSM with registered bus, strobe and completion outputs.
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      page      <= 8'h00;
      index     <= 8'h00;
      wait_cnt  <= 2'd0;
      dma_en    <= 1'b0;
      dma_addr  <= 16'h0000;
      oam_wr_en <= 1'b0;
      oam_data  <= 8'h00;
      done      <= 1'b0;
    end else begin
      oam_wr_en <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (reg_wr_en) begin
            page     <= reg_din;
            index    <= 8'h00;
            dma_en   <= 1'b1;
            dma_addr <= {reg_din, 8'h00};
            state    <= HALT;
          end
        end
        HALT: begin
          wait_cnt <= 2'd0;
          state    <= parity ? ALIGN : READ;
        end
        ALIGN: begin
          wait_cnt <= 2'd0;
          state    <= READ;
        end
        READ: begin
          // The strobe is registered on the last wait cycle so it is high
          // exactly while WRITE is active.
          if (wait_cnt == WAIT_LAST) begin
            oam_wr_en <= 1'b1;
            done      <= (index == 8'hFF);
            state     <= WRITE;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        WRITE: begin
          oam_data <= bus_din;
          wait_cnt <= 2'd0;
          if (index == 8'hFF) begin
            dma_en   <= 1'b0;
            dma_addr <= 16'h0000;
            state    <= IDLE;
          end else begin
            index    <= index + 8'd1;
            dma_addr <= {page, index + 8'd1};
            state    <= READ;
          end
        end
        default: begin
          dma_en   <= 1'b0;
          dma_addr <= 16'h0000;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Bus data is valid during WRITE itself, so the OAM port sees it directly
  // while the strobe is high and the last written byte is held otherwise.
  assign oam_din = oam_wr_en ? bus_din : oam_data;

endmodule

// File: tb/tb_oam_dma.sv
// Testbench for oam_dma: two instances (RD_LAT=1 and RD_LAT=2) with bus
// memory models, a write scoreboard and directed transfer scenarios.
module tb_oam_dma;

  logic        cpu_clock = 1'b0;
  logic        reset_n   = 1'b0;
  logic        trg  [2];
  logic [7:0]  din  [2];
  logic [7:0]  bd   [2];
  logic        en   [2];
  logic [15:0] addr [2];
  logic        we   [2];
  logic [7:0]  od   [2];
  logic        dn   [2];
  logic [7:0]  s2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [23:0] q0[$];
  logic [23:0] q1[$];

  logic [7:0] cur_page [2];
  int  len      [2];
  int  last_len [2];
  int  falls    [2];
  int  dones    [2];
  int  nw       [2];
  int  last_wr  [2];
  logic prev_en [2];
  logic tb_par;

  always #5 cpu_clock = ~cpu_clock;

  oam_dma #(.RD_LAT(1)) dut1 (
    .cpu_clock(cpu_clock), .reset_n(reset_n), .reg_wr_en(trg[0]), .reg_din(din[0]),
    .bus_din(bd[0]), .dma_en(en[0]), .dma_addr(addr[0]), .oam_wr_en(we[0]),
    .oam_din(od[0]), .done(dn[0])
  );

  oam_dma #(.RD_LAT(2)) dut2 (
    .cpu_clock(cpu_clock), .reset_n(reset_n), .reg_wr_en(trg[1]), .reg_din(din[1]),
    .bus_din(bd[1]), .dma_en(en[1]), .dma_addr(addr[1]), .oam_wr_en(we[1]),
    .oam_din(od[1]), .done(dn[1])
  );

  // Memory contents: RAM pages $02/$03 and a ROM page at $80.
  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    case (a[15:8])
      8'h02:   return lo ^ 8'h5A;
      8'h03:   return lo ^ 8'hA5;
      8'h80:   return 8'(lo * 8'd3 + 8'd7);
      default: return a[15:8] ^ lo;
    endcase
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  // Registered bus read paths with one and two cycles of latency.
  always @(posedge cpu_clock) begin
    bd[0] <= mem_rd(addr[0]);
    s2    <= mem_rd(addr[1]);
    bd[1] <= s2;
    cyc   <= cyc + 1;
  end

  // Reference cycle parity: toggles each clock, cleared by reset.
  always @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) tb_par <= 1'b0;
    else          tb_par <= ~tb_par;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      $error("%s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int q_size(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [23:0] q_pop(input int k);
    return (k == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  // Per-instance monitor: scoreboard pop on writes, spacing, done and busy length.
  task automatic mon(input int k);
    logic [23:0] e;
    if (!reset_n) begin
      len[k] = 0; prev_en[k] = 1'b0; nw[k] = 0;
      return;
    end
    if (en[k]) begin
      if (!prev_en[k]) nw[k] = 0;
      len[k]++;
      chk($sformatf("addr_page%0d", k), {24'h0, addr[k][15:8]}, {24'h0, cur_page[k]});
    end else begin
      chk($sformatf("addr_idle%0d", k), {16'h0, addr[k]}, 32'h0);
      if (prev_en[k]) begin
        last_len[k] = len[k];
        len[k] = 0;
        falls[k]++;
      end
    end
    if (we[k]) begin
      if (q_size(k) == 0) begin
        chk($sformatf("extra_write%0d", k), 32'd1, 32'd0);
      end else begin
        e = q_pop(k);
        chk($sformatf("wr_addr%0d", k), {16'h0, addr[k]}, {16'h0, e[23:8]});
        chk($sformatf("wr_data%0d", k), {24'h0, od[k]}, {24'h0, e[7:0]});
      end
      if (nw[k] > 0) chk($sformatf("wr_gap%0d", k), cyc - last_wr[k], lat(k) + 1);
      last_wr[k] = cyc;
      nw[k]++;
      chk($sformatf("done_last%0d", k), {31'h0, dn[k]}, {31'h0, nw[k] == 256});
    end else if (dn[k]) begin
      chk($sformatf("done_nowr%0d", k), 32'd1, 32'd0);
    end
    if (dn[k]) dones[k]++;
    prev_en[k] = en[k];
  endtask

  always @(negedge cpu_clock) begin
    mon(0);
    mon(1);
  end

  task automatic tick();
    @(negedge cpu_clock);
    #1;
  endtask

  // Issue a trigger; optionally wait for the parity that yields align=want.
  task automatic trig(input int k, input logic [7:0] pg, input bit wait_par,
                      input bit want, input bit push, output bit align);
    if (wait_par && (tb_par == want)) tick();
    align = ~tb_par;
    trg[k] = 1'b1;
    din[k] = pg;
    if (push) begin
      cur_page[k] = pg;
      for (int i = 0; i < 256; i++) begin
        if (k == 0) q0.push_back({pg, 8'(i), mem_rd({pg, 8'(i)})});
        else        q1.push_back({pg, 8'(i), mem_rd({pg, 8'(i)})});
      end
    end
    tick();
    trg[k] = 1'b0;
    din[k] = 8'h00;
    if (push) chk($sformatf("en_rise%0d", k), {31'h0, en[k]}, 32'd1);
  endtask

  task automatic wait_done(input int k, input int exp_len, input string tag);
    int f0, d0, n;
    f0 = falls[k]; d0 = dones[k]; n = 0;
    while (falls[k] == f0 && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, {31'h0, falls[k] == f0}, 32'd0);
    chk({tag, "_len"}, last_len[k], exp_len);
    chk({tag, "_done_cnt"}, dones[k] - d0, 32'd1);
    chk({tag, "_queue"}, q_size(k), 32'd0);
  endtask

  task automatic check_idle_outputs(input int k, input string tag);
    chk({tag, "_en"},   {31'h0, en[k]},   32'h0);
    chk({tag, "_addr"}, {16'h0, addr[k]}, 32'h0);
    chk({tag, "_we"},   {31'h0, we[k]},   32'h0);
    chk({tag, "_din"},  {24'h0, od[k]},   32'h0);
    chk({tag, "_done"}, {31'h0, dn[k]},   32'h0);
  endtask

  initial begin
    bit a;
    int d0, n;
    for (int k = 0; k < 2; k++) begin
      trg[k] = 1'b0; din[k] = 8'h00; cur_page[k] = 8'h00;
      len[k] = 0; last_len[k] = 0; falls[k] = 0; dones[k] = 0;
      nw[k] = 0; last_wr[k] = 0; prev_en[k] = 1'b0;
    end

    // Reset state
    #1;
    check_idle_outputs(0, "rst1");
    check_idle_outputs(1, "rst2");
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    $display("step reset: outputs idle");

    // Basic transfer, even alignment
    trig(0, 8'h02, 1'b1, 1'b0, 1'b1, a);
    wait_done(0, 1 + a + 512, "basic_even");
    $display("step basic_even: align=%0d len=%0d", a, last_len[0]);
    repeat (4) tick();

    // Odd alignment, same data
    trig(0, 8'h02, 1'b1, 1'b1, 1'b1, a);
    wait_done(0, 1 + a + 512, "basic_odd");
    $display("step basic_odd: align=%0d len=%0d", a, last_len[0]);
    repeat (4) tick();

    // Latency 2 from ROM page $80
    trig(1, 8'h80, 1'b1, 1'b0, 1'b1, a);
    wait_done(1, 1 + a + 768, "lat2_rom");
    $display("step lat2_rom: align=%0d len=%0d", a, last_len[1]);
    repeat (4) tick();

    // Retrigger mid-transfer is ignored
    trig(0, 8'h02, 1'b1, 1'b0, 1'b1, a);
    repeat (200) tick();
    trg[0] = 1'b1; din[0] = 8'h03;
    tick();
    trg[0] = 1'b0; din[0] = 8'h00;
    wait_done(0, 1 + a + 512, "retrig");
    d0 = dones[0];
    repeat (20) tick();
    chk("retrig_no_restart", {31'h0, en[0]}, 32'd0);
    chk("retrig_no_done", dones[0] - d0, 32'd0);
    $display("step retrig: len=%0d", last_len[0]);

    // Reset after 100 writes
    trig(0, 8'h02, 1'b1, 1'b1, 1'b1, a);
    n = 0;
    while (nw[0] < 100 && n < 1000) begin
      tick();
      n++;
    end
    chk("rstmid_reach100", nw[0], 32'd100);
    d0 = dones[0];
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_outputs(0, "rstmid_async");
    q0.delete();
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("rstmid_no_done", dones[0] - d0, 32'd0);
    check_idle_outputs(0, "rstmid_after");
    trig(0, 8'h02, 1'b1, 1'b0, 1'b1, a);
    wait_done(0, 1 + a + 512, "rstmid_fresh");
    $display("step reset_mid: fresh len=%0d", last_len[0]);
    repeat (4) tick();

    // Back-to-back transfers
    trig(0, 8'h02, 1'b1, 1'b0, 1'b1, a);
    wait_done(0, 1 + a + 512, "b2b_first");
    trig(0, 8'h02, 1'b0, 1'b0, 1'b1, a);
    wait_done(0, 1 + a + 512, "b2b_second");
    $display("step back_to_back: second align=%0d len=%0d", a, last_len[0]);
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
